// File: rtl/running_extrema.sv
`default_nettype none
// =============================================================================
// running_extrema -- streaming signed min/max tracker with first-occurrence
//                    indices and a per-sample compare code against the max.
// Optional feature macro: RUNNING_EXTREMA_FLUSH_EN (adds in_last early flush).
// Revision: 1.0
// =============================================================================
module running_extrema #(
    parameter int WIDTH     = 3,
    parameter int FRAME_LEN = 8,
    localparam int IDXW     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef RUNNING_EXTREMA_FLUSH_EN
    input  logic             in_last,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [IDXW-1:0]  out_max_idx,
    output logic [IDXW-1:0]  out_min_idx,
    output logic [1:0]       cmp_code
);

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0]      C_CMP_EQ   = 2'b00;
    localparam logic [1:0]      C_CMP_GT   = 2'b01;
    localparam logic [1:0]      C_CMP_LT   = 2'b10;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(FRAME_LEN - 1);

    state_t           r_state;
    logic [IDXW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [IDXW-1:0]  r_max_idx;
    logic [IDXW-1:0]  r_min_idx;

    logic             w_accept;
    logic             w_end_frame;
    logic [WIDTH-1:0] w_nxt_max;
    logic [WIDTH-1:0] w_nxt_min;
    logic [IDXW-1:0]  w_nxt_max_idx;
    logic [IDXW-1:0]  w_nxt_min_idx;
    logic [1:0]       w_cmp;

    assign in_ready = !rst && (r_state != S_HOLD);
    assign w_accept = in_valid && in_ready;

    // Running extrema after the current sample; strict compares keep the
    // earliest index on ties.
    always_comb begin
        w_nxt_max     = r_max;
        w_nxt_min     = r_min;
        w_nxt_max_idx = r_max_idx;
        w_nxt_min_idx = r_min_idx;
        w_cmp         = C_CMP_EQ;
        if (r_state == S_FIRST) begin
            w_nxt_max     = in_data;
            w_nxt_min     = in_data;
            w_nxt_max_idx = '0;
            w_nxt_min_idx = '0;
        end else begin
            if ($signed(in_data) > $signed(r_max)) begin
                w_nxt_max     = in_data;
                w_nxt_max_idx = r_cnt;
                w_cmp         = C_CMP_GT;
            end else if ($signed(in_data) < $signed(r_max)) begin
                w_cmp         = C_CMP_LT;
            end
            if ($signed(in_data) < $signed(r_min)) begin
                w_nxt_min     = in_data;
                w_nxt_min_idx = r_cnt;
            end
        end
    end

    always_comb begin
        w_end_frame = 1'b0;
        if (r_state == S_FIRST) begin
            w_end_frame = (FRAME_LEN < 2);
        end else if (r_state == S_ACCUM) begin
            w_end_frame = (r_cnt == C_LAST_IDX);
        end
`ifdef RUNNING_EXTREMA_FLUSH_EN
        if (in_last) begin
            w_end_frame = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FIRST;
            r_cnt       <= '0;
            r_max       <= '0;
            r_min       <= '0;
            r_max_idx   <= '0;
            r_min_idx   <= '0;
            out_valid   <= 1'b0;
            out_max     <= '0;
            out_min     <= '0;
            out_max_idx <= '0;
            out_min_idx <= '0;
            cmp_code    <= C_CMP_EQ;
        end else begin
            case (r_state)
                S_FIRST, S_ACCUM: begin
                    if (w_accept) begin
                        r_max     <= w_nxt_max;
                        r_min     <= w_nxt_min;
                        r_max_idx <= w_nxt_max_idx;
                        r_min_idx <= w_nxt_min_idx;
                        cmp_code  <= w_cmp;
                        r_cnt     <= r_cnt + IDXW'(1);
                        if (w_end_frame) begin
                            // Publish at the completing accept so out_* only
                            // change between frames.
                            r_state     <= S_HOLD;
                            out_valid   <= 1'b1;
                            out_max     <= w_nxt_max;
                            out_min     <= w_nxt_min;
                            out_max_idx <= w_nxt_max_idx;
                            out_min_idx <= w_nxt_min_idx;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_FIRST;
                    end
                end
                default: begin
                    r_state <= S_FIRST;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
